// File: rtl/button_capture.sv
// rtl/button_capture.sv - debounced button capture with rise/fall latches and level interrupt
// Each pin is synchronized, debounced by a per-bit hold counter, and its accepted edges latched.
module button_capture #(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out,
  output logic                   irq_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_RISE   = 2'd1;
  localparam logic [1:0] ADDR_FALL   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

  logic [BUTTONCOUNT-1:0] sync1, sync2;
  logic [BUTTONCOUNT-1:0] state, state_next;
  logic [BUTTONCOUNT-1:0] rise, fall, irq_en;
  logic [BUTTONCOUNT-1:0] rise_set, fall_set, rise_clr, fall_clr;
  logic [BUTTONCOUNT-1:0] wdata, reg_val;
  logic [CW-1:0]          cnt      [BUTTONCOUNT];
  logic [CW-1:0]          cnt_next [BUTTONCOUNT];
  logic [1:0]             reg_sel;
  logic                   wr_en;
  logic                   unused;

  assign reg_sel = address_in[3:2];
  assign wr_en   = sel_in & write_mask_in[0];
  assign wdata   = write_value_in[BUTTONCOUNT-1:0];

  // Only bits [3:2] of the address, mask bit 0 and the low data bits matter; reads are side-effect free.
  assign unused = ^{read_in, address_in[31:4], address_in[1:0], write_mask_in[3:1],
                    write_value_in[31:BUTTONCOUNT]};

  // A differing level must be seen on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    state_next = state;
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != state[i]) begin
        if (cnt[i] == CNT_MAX) begin
          state_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise_set = state_next & ~state;
  assign fall_set = ~state_next & state;
  assign rise_clr = (wr_en && reg_sel == ADDR_RISE) ? wdata : '0;
  assign fall_clr = (wr_en && reg_sel == ADDR_FALL) ? wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      state  <= '0;
      rise   <= '0;
      fall   <= '0;
      irq_en <= '0;
      for (int i = 0; i < BUTTONCOUNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= buttons_in;
      sync2 <= sync1;
      state <= state_next;
      for (int i = 0; i < BUTTONCOUNT; i++) begin
        cnt[i] <= cnt_next[i];
      end
      // A new edge outranks a simultaneous write-1-to-clear.
      rise <= (rise & ~rise_clr) | rise_set;
      fall <= (fall & ~fall_clr) | fall_set;
      if (wr_en && reg_sel == ADDR_IRQ_EN) begin
        irq_en <= wdata;
      end
    end
  end

  always_comb begin
    reg_val = '0;
    case (reg_sel)
      ADDR_STATE:  reg_val = state;
      ADDR_RISE:   reg_val = rise;
      ADDR_FALL:   reg_val = fall;
      ADDR_IRQ_EN: reg_val = irq_en;
      default:     reg_val = '0;
    endcase
  end

  assign read_value_out = sel_in ? {{(32 - BUTTONCOUNT){1'b0}}, reg_val} : 32'd0;
  assign ready_out      = sel_in;
  assign irq_out        = |((rise | fall) & irq_en);

endmodule

// File: tb/tb_button_capture.sv
// tb/tb_button_capture.sv - self-checking bench for button_capture
module tb_button_capture;

  localparam int BC = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BC-1:0] buttons;
  logic [31:0]   address;
  logic          sel;
  logic          read;
  logic [31:0]   read_value;
  logic [3:0]    write_mask;
  logic [31:0]   write_value;
  logic          ready;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  button_capture #(.BUTTONCOUNT(BC), .DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .reset          (reset),
    .buttons_in     (buttons),
    .address_in     (address),
    .sel_in         (sel),
    .read_in        (read),
    .read_value_out (read_value),
    .write_mask_in  (write_mask),
    .write_value_in (write_value),
    .ready_out      (ready),
    .irq_out        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the synchronized pin, i.e. the pin as it was two
  // edges earlier, has disagreed with the accepted level on each of the last D edges since reset.
  logic [BC-1:0] m_state, m_rise, m_fall, m_en;
  logic [BC-1:0] pin_hist  [$];
  logic [BC-1:0] sync_hist [$];
  logic [BC-1:0] m_v, m_flip, m_new, m_cr, m_cf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = '0; m_rise = '0; m_fall = '0; m_en = '0;
      pin_hist.delete();
      sync_hist.delete();
    end else begin
      m_v = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size() - 2] : '0;
      pin_hist.push_back(buttons);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
      sync_hist.push_back(m_v);
      if (sync_hist.size() > D) void'(sync_hist.pop_front());
      m_flip = '0;
      if (sync_hist.size() == D) begin
        for (int b = 0; b < BC; b++) begin
          m_flip[b] = 1'b1;
          foreach (sync_hist[k]) if (sync_hist[k][b] == m_state[b]) m_flip[b] = 1'b0;
        end
      end
      m_new = m_state ^ m_flip;
      m_cr = '0; m_cf = '0;
      if (sel && write_mask[0]) begin
        case (address[3:2])
          2'd1: m_cr = write_value[BC-1:0];
          2'd2: m_cf = write_value[BC-1:0];
          2'd3: m_en = write_value[BC-1:0];
          default: ;
        endcase
      end
      m_rise  = (m_rise & ~m_cr) | (m_flip & m_new);
      m_fall  = (m_fall & ~m_cf) | (m_flip & ~m_new);
      m_state = m_new;
    end
  end

  function automatic logic [31:0] exp_read(input logic s, input logic [31:0] a);
    logic [BC-1:0] r;
    if (!s) return 32'd0;
    case (a[3:2])
      2'd0: r = m_state;
      2'd1: r = m_rise;
      2'd2: r = m_fall;
      default: r = m_en;
    endcase
    return {{(32 - BC){1'b0}}, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BC-1:0] btn;
    logic          s;
    logic [31:0]   a;
    logic [3:0]    m;
    logic [31:0]   w;
    logic [31:0]   exp_rd;
    logic          exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [BC-1:0] b, input logic s, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] w, input logic [31:0] r, input logic q);
    vec_t v;
    v.btn = b; v.s = s; v.a = a; v.m = m; v.w = w; v.exp_rd = r; v.exp_irq = q;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [BC-1:0] b, input logic [31:0] a, input logic [31:0] r);
    for (int k = 0; k < n; k++) add(b, 1'b1, a, 4'h0, 32'd0, r, 1'b0);
  endtask

  initial begin
    reset = 1'b0; buttons = '0; address = '0; sel = 1'b0; read = 1'b0;
    write_mask = '0; write_value = '0;

    // Glitch of 3 cycles is rejected
    add_n(3, 4'h1, 32'h0, 32'h0);
    add_n(6, 4'h0, 32'h0, 32'h0);
    add(4'h0, 1, 32'h4, 4'h0, 0, 32'h0, 0);
    add(4'h0, 1, 32'h8, 4'h0, 0, 32'h0, 0);
    // Clean step accepted on the sixth edge
    add_n(5, 4'h1, 32'h0, 32'h0);
    add(4'h1, 1, 32'h0, 4'h0, 0, 32'h1, 0);
    add(4'h1, 1, 32'h4, 4'h0, 0, 32'h1, 0);
    add(4'h1, 1, 32'h8, 4'h0, 0, 32'h0, 0);
    add(4'h1, 0, 32'h0, 4'h0, 0, 32'h0, 0);
    add(4'h1, 0, 32'hC, 4'h1, 32'hF, 32'h0, 0);
    add(4'h1, 1, 32'h4, 4'h1, 32'h1, 32'h0, 0);
    // Fall, then W1C of FALL
    add_n(5, 4'h0, 32'h8, 32'h0);
    add(4'h0, 1, 32'h8, 4'h0, 0, 32'h1, 0);
    add(4'h0, 1, 32'h8, 4'h1, 32'h1, 32'h0, 0);
    // IRQ_EN write, masked-off write, STATE write ignored
    add(4'h0, 1, 32'hC, 4'h1, 32'h3, 32'h3, 0);
    add(4'h0, 1, 32'hC, 4'hE, 32'hF, 32'h3, 0);
    add(4'h0, 1, 32'h0, 4'h1, 32'hF, 32'h0, 0);
    // Bit1 rise raises irq; W1C drops it
    add_n(5, 4'h2, 32'h4, 32'h0);
    add(4'h2, 1, 32'h4, 4'h0, 0, 32'h2, 1);
    add(4'h2, 1, 32'h4, 4'h1, 32'h2, 32'h0, 0);
    // W1C of RISE[0] on the edge where bit0 rises: set wins
    add_n(5, 4'h3, 32'h4, 32'h0);
    add(4'h3, 1, 32'h4, 4'h1, 32'h1, 32'h1, 1);
    add(4'h3, 1, 32'h0, 4'h0, 0, 32'h3, 1);

    repeat (2) @(posedge clk);
    #1;
    sel = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 32'(a * 4);
      #1;
      chk($sformatf("reset_reg%0d", a), read_value, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (tbl[i]) begin
      buttons = tbl[i].btn; sel = tbl[i].s; address = tbl[i].a;
      write_mask = tbl[i].m; write_value = tbl[i].w;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rd", i), read_value, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      chk($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, tbl[i].s});
    end

    // Reset asserted mid-debounce (counter at 2) discards the count
    buttons = 4'h7; sel = 1'b1; address = 32'h0; write_mask = 4'h0; write_value = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("pre_reset_state", read_value, 32'h3);
    end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 32'(a * 4);
      #1;
      chk($sformatf("midrst_reg%0d", a), read_value, 32'd0);
    end
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    address = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_state_e%0d", k), read_value, (k == 6) ? 32'h7 : 32'h0);
    end
    address = 32'h4;
    #1;
    chk("post_rst_rise", read_value, 32'h7);

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < BC; b++) if ($urandom_range(0, 7) == 0) buttons[b] = ~buttons[b];
      sel = 1'($urandom_range(0, 1));
      read = 1'($urandom_range(0, 1));
      address = $urandom;
      write_mask = 4'($urandom);
      write_value = $urandom;
      reset = (c == 700 || c == 701) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("rnd%0d_rd", c), read_value, exp_read(sel, address));
      chk($sformatf("rnd%0d_irq", c), {31'd0, irq}, {31'd0, |((m_rise | m_fall) & m_en)});
      chk($sformatf("rnd%0d_ready", c), {31'd0, ready}, {31'd0, sel});
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
